photon_sequencer: RTL and testbench
===================================

# photon_sequencer

Run controller for the photon pulse generator. It holds the generator's configuration: pulse full width, detection efficiency, inter-pulse period, pulse count and initial delay. On command it issues a timed train of one-cycle trigger strobes to the generator, keeping the configuration frozen for the whole run. It sits between the host command decoder (register writes plus start/abort) and the `photon` block, whose `full_width` and `detect_efficiency` inputs it drives.

## Interface

Parameters:
- `FW_W`, 16: width of full_width.
- `EFF_W`, 8: width of detect_efficiency.
- `TIM_W`, 24: width of the period and delay fields; also the cfg_wdata width.
- `CNT_W`, 16: width of the pulse count and of pulse_idx.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_we`  in  1  staging register write strobe.
- `cfg_addr`  in  3  register select: 0 full_width, 1 detect_efficiency, 2 period, 3 count, 4 delay; 5–7 ignored.
- `cfg_wdata`  in  TIM_W  write data; each field takes its low bits.
- `start`  in  1  run request, level-sampled each cycle.
- `abort`  in  1  terminate the current run.
- `full_width`  out  FW_W  active full width to the photon generator.
- `detect_efficiency`  out  EFF_W  active efficiency to the photon generator.
- `pulse_trig`  out  1  one-cycle trigger per pulse.
- `pulse_idx`  out  CNT_W  0-based index of the current or last pulse.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle strobe on normal run completion.

## Operation

**Register model**
- Two register sets: staging (written by cfg_we) and active (drives the outputs and timing).
- Staging writes are accepted in every state. They never affect a run in progress.
- An accepted start copies staging into active. If cfg_we hits the same cycle as an accepted start, the copy takes the pre-write staging value and the write lands in staging.

**State machine** (IDLE, WAIT, FIRE; timer is TIM_W bits, idx is CNT_W bits)
- IDLE, start=1, staged count≠0:
  - copy staging to active;
  - timer ← staged delay, idx ← 0;
  - go to WAIT.
- IDLE, start=1, staged count=0: copy staging to active, stay in IDLE, pulse done next cycle, no trigger.
- WAIT: if timer=0, go to FIRE; otherwise timer ← timer−1.
- FIRE (pulse_trig=1, pulse_idx=idx):
  - if idx=count−1, go to IDLE and pulse done;
  - otherwise timer ← Peff−2, idx ← idx+1 (idx visible from the next FIRE), go to WAIT.
- Peff = max(period, 2). Period values 0 and 1 are clamped to 2.
- start outside IDLE is ignored; no queuing.
- abort in WAIT or FIRE: next state IDLE, no done.
  - A FIRE cycle coincident with abort still shows its trigger.
  - abort overrides completion on the last FIRE.
  - abort in IDLE has no effect, and start is still accepted that cycle.

**Outputs**
- busy=1 exactly while the state is WAIT or FIRE.
- pulse_trig=1 exactly in FIRE cycles.
- done is a registered one-cycle strobe.
- pulse_idx holds its last value after the run ends or is aborted.

**Reset** (asynchronous, any state)
- State → IDLE.
- All staging and active registers → 0.
- All outputs → 0.

## Timing

- Start sampled high in IDLE at edge 0:
  - busy and the new full_width/detect_efficiency appear at cycle 1;
  - first pulse_trig at cycle delay+2.
- Trigger spacing is exactly Peff cycles.
- After the last trigger at cycle t: done=1 and busy=0 at cycle t+1.
- A new start is accepted at cycle t+1, giving back-to-back runs.
- count=0 start at cycle 0: done at cycle 1, busy stays 0.
- abort sampled at cycle a: busy=0 and pulse_trig=0 from cycle a+1.
- Total run length: delay+1+(count−1)·Peff+1 busy cycles.
- Arithmetic is unsigned, with no wrap. The timer never decrements below 0. count up to 2^CNT_W−1 is supported.

## Test plan

1. **Reset.** Assert rst mid-run (busy=1) → all outputs 0 immediately, with no clock edge required. After release, start with default staging (count=0) → done at +1, no trigger.
2. **Basic run.** Write fw=40, eff=200, period=5, count=3, delay=0; start at cycle 0 →
   - full_width=40 and eff=200 from cycle 1;
   - pulse_trig at cycles 2, 7, 12 with pulse_idx 0, 1, 2;
   - busy for cycles 1–12;
   - done at cycle 13 only.
3. **Delay and clamp.** Write period=1, count=2, delay=3 → triggers at cycles 5 and 7 (period treated as 2).
4. **Abort.** Abort one cycle after the second trigger of a period=10, count=5 run →
   - busy=0 on the next cycle, no further triggers, no done, pulse_idx=1 held;
   - a new start then runs normally from idx 0.
5. **Frozen configuration.** During a run, write fw=99 and pulse start →
   - full_width unchanged and the start ignored;
   - the next accepted start drives full_width=99 from cycle 1.
6. **Simultaneous events.** Write addr 0 in the same cycle as start → the run uses the old fw. Assert start and abort together in IDLE → the run starts.

Source files
------------

// File: rtl/photon_sequencer.sv
// photon_sequencer: run controller for the photon pulse generator.
// Holds a staging and an active copy of the generator configuration and, on
// start, plays out a timed train of one-cycle trigger strobes while the active
// configuration stays frozen.
//
// Control semantics: start and abort are level-sampled requests with no
// ready/acknowledge. start is only honoured in IDLE (no queuing). abort is
// only honoured in WAIT or FIRE. cfg_we is accepted unconditionally in every
// state and only ever lands in the staging set.
module photon_sequencer #(
  parameter int FW_W  = 16,
  parameter int EFF_W = 8,
  parameter int TIM_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [TIM_W-1:0] cfg_wdata,
  input  logic             start,
  input  logic             abort,
  output logic [FW_W-1:0]  full_width,
  output logic [EFF_W-1:0] detect_efficiency,
  output logic             pulse_trig,
  output logic [CNT_W-1:0] pulse_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;

  localparam logic [2:0] ADDR_FW    = 3'd0;
  localparam logic [2:0] ADDR_EFF   = 3'd1;
  localparam logic [2:0] ADDR_PER   = 3'd2;
  localparam logic [2:0] ADDR_CNT   = 3'd3;
  localparam logic [2:0] ADDR_DELAY = 3'd4;

  // Staging set (host visible, written any time).
  logic [FW_W-1:0]  stg_fw;
  logic [EFF_W-1:0] stg_eff;
  logic [TIM_W-1:0] stg_period;
  logic [CNT_W-1:0] stg_count;
  logic [TIM_W-1:0] stg_delay;

  // Active set (frozen for the duration of a run).
  logic [FW_W-1:0]  act_fw;
  logic [EFF_W-1:0] act_eff;
  logic [CNT_W-1:0] act_count;
  logic [TIM_W-1:0] act_gap;     // effective period minus 2, the WAIT reload

  // Sequencer state.
  logic [1:0]       state;
  logic [TIM_W-1:0] timer;
  logic [CNT_W-1:0] idx;

  logic             launch;
  logic             last_pulse;
  logic [TIM_W-1:0] stg_gap;

  // A start request is only taken while idle.
  assign launch = (state == ST_IDLE) && start;

  // Final pulse of the run: idx has reached count-1 (count is nonzero in FIRE).
  assign last_pulse = (idx == (act_count - CNT_W'(1)));

  // Period values 0 and 1 behave as 2, so the reload never underflows.
  assign stg_gap = (stg_period < TIM_W'(2)) ? '0 : (stg_period - TIM_W'(2));

  // Staging register writes; addresses 5-7 are silently dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_fw     <= '0;
      stg_eff    <= '0;
      stg_period <= '0;
      stg_count  <= '0;
      stg_delay  <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_FW:    stg_fw     <= cfg_wdata[FW_W-1:0];
        ADDR_EFF:   stg_eff    <= cfg_wdata[EFF_W-1:0];
        ADDR_PER:   stg_period <= cfg_wdata;
        ADDR_CNT:   stg_count  <= cfg_wdata[CNT_W-1:0];
        ADDR_DELAY: stg_delay  <= cfg_wdata;
        default:    ;
      endcase
    end
  end

  // Snapshot staging into the active set on an accepted start; a coincident
  // staging write is not seen here because it lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_fw    <= '0;
      act_eff   <= '0;
      act_count <= '0;
      act_gap   <= '0;
    end else if (launch) begin
      act_fw    <= stg_fw;
      act_eff   <= stg_eff;
      act_count <= stg_count;
      act_gap   <= stg_gap;
    end
  end

  // Run sequencer: IDLE -> WAIT (count down) -> FIRE (one strobe) -> WAIT ...
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      idx       <= '0;
      pulse_idx <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (stg_count != '0) begin
              state <= ST_WAIT;
              timer <= stg_delay;
              idx   <= '0;
            end else begin
              // Empty run: completes immediately without a trigger.
              done <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (timer == '0) begin
            state     <= ST_FIRE;
            pulse_idx <= idx;
          end else begin
            timer <= timer - TIM_W'(1);
          end
        end
        ST_FIRE: begin
          if (abort) begin
            // Abort wins over completion, so no done strobe.
            state <= ST_IDLE;
          end else if (last_pulse) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            state <= ST_WAIT;
            timer <= act_gap;
            idx   <= idx + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state so reset clears them at once.
  assign busy              = (state == ST_WAIT) || (state == ST_FIRE);
  assign pulse_trig        = (state == ST_FIRE);
  assign full_width        = act_fw;
  assign detect_efficiency = act_eff;

endmodule

// File: tb/tb_photon_sequencer.sv
// Testbench for photon_sequencer: scenario tasks compare every output each
// cycle against a timeline computed from the configured delay/period/count.
module tb_photon_sequencer;

  localparam int FW_W  = 16;
  localparam int EFF_W = 8;
  localparam int TIM_W = 24;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             cfg_we;
  logic [2:0]       cfg_addr;
  logic [TIM_W-1:0] cfg_wdata;
  logic             start;
  logic             abort;
  logic [FW_W-1:0]  full_width;
  logic [EFF_W-1:0] detect_efficiency;
  logic             pulse_trig;
  logic [CNT_W-1:0] pulse_idx;
  logic             busy;
  logic             done;

  photon_sequencer #(
    .FW_W(FW_W), .EFF_W(EFF_W), .TIM_W(TIM_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .abort(abort),
    .full_width(full_width), .detect_efficiency(detect_efficiency),
    .pulse_trig(pulse_trig), .pulse_idx(pulse_idx),
    .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model state ----------------
  logic [FW_W-1:0]  s_fw,  a_fw;
  logic [EFF_W-1:0] s_eff, a_eff;
  logic [TIM_W-1:0] s_per, s_dly;
  logic [CNT_W-1:0] s_cnt;
  logic [CNT_W-1:0] m_idx;

  task automatic model_clear();
    s_fw = '0; s_eff = '0; s_per = '0; s_dly = '0; s_cnt = '0;
    a_fw = '0; a_eff = '0; m_idx = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [TIM_W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
    case (a)
      3'd0: s_fw  = d[FW_W-1:0];
      3'd1: s_eff = d[EFF_W-1:0];
      3'd2: s_per = d;
      3'd3: s_cnt = d[CNT_W-1:0];
      3'd4: s_dly = d;
      default: ;
    endcase
  endtask

  task automatic set_cfg(input int fw, input int eff, input int per, input int cnt, input int dly);
    cfg_write(3'd0, TIM_W'(fw));
    cfg_write(3'd1, TIM_W'(eff));
    cfg_write(3'd2, TIM_W'(per));
    cfg_write(3'd3, TIM_W'(cnt));
    cfg_write(3'd4, TIM_W'(dly));
  endtask

  // Launches (unless already launched) and checks one run cycle by cycle.
  // Trigger k sits at cycle delay+2+k*Peff; an abort sampled at cycle a
  // truncates everything after cycle a and suppresses done.
  task automatic do_run(input int abort_at, input int poke_at, input logic [FW_W-1:0] poke_fw,
                        input bit wr_with_start, input logic [TIM_W-1:0] wr_data,
                        input bit abort_with_start, input bit launched, input bit chain);
    int peff, first, last, stop, fin, end_c, cnt;
    logic eb, et, ed;
    cnt   = int'(s_cnt);
    peff  = (s_per < 2) ? 2 : int'(s_per);
    first = int'(s_dly) + 2;
    last  = (cnt == 0) ? 0 : first + (cnt - 1) * peff;
    stop  = (abort_at > 0) ? abort_at : (1 << 30);
    fin   = (stop < last) ? stop : last;
    end_c = chain ? last + 1 : fin + 3;
    if (!launched) begin
      start = 1'b1;
      abort = abort_with_start;
      if (wr_with_start) begin
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = wr_data;
      end
      step();
      start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    end
    a_fw  = s_fw;
    a_eff = s_eff;
    if (wr_with_start) s_fw = wr_data[FW_W-1:0];
    for (int c = 1; c <= end_c; c++) begin
      eb = (cnt != 0) && (c <= last) && (c <= stop);
      et = (cnt != 0) && (c >= first) && (c <= last) && (c <= stop) && (((c - first) % peff) == 0);
      if (et) m_idx = CNT_W'((c - first) / peff);
      ed = (cnt == 0) ? (c == 1) : ((c == last + 1) && (stop > last));
      n_vec += 6;
      if (busy !== eb) begin
        n_err++; $display("FAIL busy cyc=%0d got=%0b exp=%0b", c, busy, eb);
      end
      if (pulse_trig !== et) begin
        n_err++; $display("FAIL pulse_trig cyc=%0d got=%0b exp=%0b", c, pulse_trig, et);
      end
      if (done !== ed) begin
        n_err++; $display("FAIL done cyc=%0d got=%0b exp=%0b", c, done, ed);
      end
      if (pulse_idx !== m_idx) begin
        n_err++; $display("FAIL pulse_idx cyc=%0d got=%0d exp=%0d", c, pulse_idx, m_idx);
      end
      if (full_width !== a_fw) begin
        n_err++; $display("FAIL full_width cyc=%0d got=%0d exp=%0d", c, full_width, a_fw);
      end
      if (detect_efficiency !== a_eff) begin
        n_err++; $display("FAIL detect_efficiency cyc=%0d got=%0d exp=%0d", c, detect_efficiency, a_eff);
      end
      abort = (c == abort_at);
      if (c == poke_at) begin
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = TIM_W'(poke_fw);
        start = 1'b1;
        s_fw = poke_fw;
      end
      if (chain && c == end_c) start = 1'b1;
      step();
      abort = 1'b0; cfg_we = 1'b0; start = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_vec += 4;
    if (busy !== 1'b0 || pulse_trig !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL por_ctrl got=%0b%0b%0b exp=000", busy, pulse_trig, done);
    end
    if (full_width !== '0) begin
      n_err++; $display("FAIL por_fw got=%0d exp=0", full_width);
    end
    if (detect_efficiency !== '0) begin
      n_err++; $display("FAIL por_eff got=%0d exp=0", detect_efficiency);
    end
    if (pulse_idx !== '0) begin
      n_err++; $display("FAIL por_idx got=%0d exp=0", pulse_idx);
    end
    set_cfg(16'h1234, 8'h5a, 4, 4, 0);
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL pre_rst_busy got=%0b exp=1", busy);
    end
    #2 rst = 1'b1;
    #1;
    n_vec += 6;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    if (pulse_trig !== 1'b0) begin n_err++; $display("FAIL rst_trig got=%0b exp=0", pulse_trig); end
    if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%0b exp=0", done); end
    if (pulse_idx !== '0) begin n_err++; $display("FAIL rst_idx got=%0d exp=0", pulse_idx); end
    if (full_width !== '0) begin n_err++; $display("FAIL rst_fw got=%0d exp=0", full_width); end
    if (detect_efficiency !== '0) begin
      n_err++; $display("FAIL rst_eff got=%0d exp=0", detect_efficiency);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    model_clear();
    // Default staging has count=0: done next cycle, no trigger, never busy.
    do_run(-1, -1, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic test_basic();
    set_cfg(40, 200, 5, 3, 0);
    do_run(-1, -1, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic test_delay_clamp();
    set_cfg(41, 201, 1, 2, 3);
    do_run(-1, -1, '0, 0, '0, 0, 0, 0);
    cfg_write(3'd2, 24'd0);
    do_run(-1, -1, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic test_abort();
    set_cfg(50, 100, 10, 5, 0);
    // Triggers at 2 and 12; abort sampled at 13.
    do_run(13, -1, '0, 0, '0, 0, 0, 0);
    do_run(-1, -1, '0, 0, '0, 0, 0, 0);
    // Abort on the final FIRE cycle: trigger shown, done suppressed.
    set_cfg(51, 101, 3, 2, 1);
    do_run(6, -1, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic test_frozen();
    set_cfg(40, 200, 4, 3, 2);
    do_run(-1, 3, 16'd99, 0, '0, 0, 0, 0);
    do_run(-1, -1, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic test_simultaneous();
    set_cfg(60, 70, 3, 2, 1);
    do_run(-1, -1, '0, 1, 24'hab0077, 0, 0, 0);
    do_run(-1, -1, '0, 0, '0, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    set_cfg(11, 22, 3, 2, 1);
    do_run(-1, -1, '0, 0, '0, 0, 0, 1);
    do_run(-1, -1, '0, 0, '0, 0, 1, 0);
  endtask

  task automatic test_random();
    int per, cnt, dly, peff, last, ab;
    for (int it = 0; it < 14; it++) begin
      per = $urandom_range(0, 6);
      cnt = $urandom_range(0, 5);
      dly = $urandom_range(0, 5);
      cfg_write(3'd0, TIM_W'($urandom));
      cfg_write(3'd1, TIM_W'($urandom));
      cfg_write(3'd2, TIM_W'(per));
      cfg_write(3'd3, {8'($urandom), 16'(cnt)});
      cfg_write(3'd4, TIM_W'(dly));
      cfg_write(3'($urandom_range(5, 7)), TIM_W'($urandom));
      peff = (per < 2) ? 2 : per;
      last = dly + 2 + (cnt - 1) * peff;
      ab = -1;
      if (cnt != 0 && $urandom_range(0, 1) == 1) ab = $urandom_range(1, last + 1);
      do_run(ab, -1, '0, 0, '0, 0, 0, 0);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; abort = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    step();
    test_reset();
    test_basic();
    test_delay_clamp();
    test_abort();
    test_frozen();
    test_simultaneous();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
